count_sequence_checker: RTL and testbench
=========================================

Name: count_sequence_checker

Overview:
- Consumes the 4-bit free-running `counter` output directly downstream of it.
- Checks that every valid sample equals the previous sample +1 modulo 2^WIDTH.
- Declares lock after a run of good increments, flags mismatches, and counts errors and wrap-arounds for bench and debug visibility.
- All outputs are registered, with one cycle of latency.

Parameters:
- WIDTH, 4, width of the sampled count.
- LOCK_CYCLES, 4, consecutive good increments required to enter LOCKED (≥1).
- ERR_CNT_W, 8, width of the saturating error counter.
- WRAP_CNT_W, 8, width of the wrap counter (rolls over modulo 2^WRAP_CNT_W).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- count_in  input  WIDTH  count from the upstream counter.
- valid_in  input  1  count_in is sampled only when high.
- clear  input  1  synchronous re-acquire: returns to IDLE, keeps both counters.
- locked  output  1  high while in LOCKED.
- mismatch  output  1  one-cycle pulse on a bad increment while LOCKED.
- expected  output  WIDTH  registered prev+1, the value the next sample must equal.
- err_count  output  ERR_CNT_W  saturating count of LOCKED mismatches.
- wrap_count  output  WRAP_CNT_W  count of all-ones→0 transitions seen while LOCKED.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, prev=0, run=0, locked=0, mismatch=0, expected=0, err_count=0, wrap_count=0.
- Priority: reset > clear > normal operation.
- clear:
  - state→IDLE, run→0, mismatch→0, locked→0.
  - prev, err_count and wrap_count are held.
- valid_in low:
  - All state is held and mismatch=0.
  - Gaps never generate errors.
- good increment: count_in == (prev + 1) mod 2^WIDTH. Width-truncated add; 15→0 is good for WIDTH=4.
- On every valid sample: prev←count_in and expected←count_in+1, registered.
- State IDLE:
  - On valid: capture prev, go to ACQUIRE, run←0.
  - No comparison is made on this first sample.
- State ACQUIRE, on valid:
  - Good increment: run←run+1. When run+1 == LOCK_CYCLES, go to LOCKED (locked=1 next cycle) and run←0.
  - Bad increment: run←0, stay in ACQUIRE. No mismatch pulse and no err_count change.
- State LOCKED, on valid:
  - Good increment: stay in LOCKED. If prev is all-ones and count_in is 0, wrap_count←wrap_count+1 (modular rollover).
  - Bad increment: mismatch=1 for exactly one cycle. err_count←min(err_count+1, 2^ERR_CNT_W−1). State→ACQUIRE, run←0, locked=0 the same cycle mismatch is high.
- Upstream counter reset held: count_in repeats 0.
  - In LOCKED, the first repeat is one error; the checker then sits in ACQUIRE.
  - In ACQUIRE, repeats are not counted.
- Latency: the sample at edge N is reflected in locked, mismatch and the counters after edge N.
- run is wide enough for LOCK_CYCLES, i.e. $clog2(LOCK_CYCLES+1) bits.

Decomposition:
- Shared package `count_check_pkg`:
  - State enum typedef {IDLE, ACQUIRE, LOCKED}.
  - Default WIDTH/LOCK_CYCLES constants.
  - An all-ones helper constant per WIDTH.
- One sub-module `sat_counter` (parameter W; ports clk, reset, inc, out) is used for err_count.
- wrap_count stays a plain inline modular increment.

Test Plan:
- Lock: reset 2 cycles, then valid samples 0,1,2,3,4 → locked=0 through the sample of 3. locked=1 after the edge sampling 4. expected=5. err_count=0.
- Wrap: LOCKED, samples 13,14,15,0,1 → wrap_count 0→1 after the edge sampling 0. mismatch stays 0. locked stays 1.
- Mismatch and re-lock: LOCKED after 5, inject 7 → mismatch=1 for one cycle, err_count=1, locked=0. Then 8,9,10,11 → locked=1 after the edge sampling 11.
- Valid gap: LOCKED at 5, valid_in low 3 cycles with count_in garbage (0xA), then valid 6 → no mismatch, locked stays 1.
- Saturation: ERR_CNT_W=2; repeat 5 times (lock on 0–4, inject a bad value) → err_count ends at 3, not 1. mismatch pulses 5 times.
- Reset/clear mid-operation:
  - clear while LOCKED with err_count=2, wrap_count=1 → locked=0, counters unchanged, next sample is treated as first.
  - reset asserted together with a bad sample → mismatch=0 and all outputs return to reset values.

Source files
------------

// File: rtl/count_check_pkg.sv
// Shared types and constants for the count sequence checker.
package count_check_pkg;

    // Checker states: waiting for a first sample, building a run, locked on.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH       = 4;
    localparam int DEFAULT_LOCK_CYCLES = 4;

    // All-ones value of a given width; marks the last value before a wrap.
    function automatic logic [31:0] all_ones(input int w);
        if (w >= 32)
            return 32'hFFFF_FFFF;
        else
            return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at its maximum value.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] out
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] count_reg;

    // Increment on inc unless already at the maximum.
    always_ff @(posedge clk) begin
        if (reset)
            count_reg <= '0;
        else if (inc && (count_reg != MAX_VAL))
            count_reg <= count_reg + W'(1);
    end

    assign out = count_reg;

endmodule

// File: rtl/count_sequence_checker.sv
// Watches a free-running counter and checks each valid sample is the
// previous one plus one (modulo 2^WIDTH). Locks after a run of good
// increments, flags and counts mismatches while locked, counts wraps.
module count_sequence_checker
    import count_check_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int LOCK_CYCLES = DEFAULT_LOCK_CYCLES,
    parameter int ERR_CNT_W   = 8,
    parameter int WRAP_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  valid_in,
    input  logic                  clear,
    output logic                  locked,
    output logic                  mismatch,
    output logic [WIDTH-1:0]      expected,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [WRAP_CNT_W-1:0] wrap_count
);

    localparam int              RUN_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));

    state_t                  state_reg;
    logic [WIDTH-1:0]        prev_reg;
    logic [RUN_W-1:0]        run_reg;
    logic                    locked_reg;
    logic                    mismatch_reg;
    logic [WIDTH-1:0]        expected_reg;
    logic [WRAP_CNT_W-1:0]   wrap_reg;

    logic [WIDTH-1:0]        prev_inc;
    logic                    good;
    logic                    run_done;
    logic                    wrap_hit;
    logic                    err_inc;

    // Increment rules, evaluated against the stored previous sample.
    assign prev_inc = prev_reg + WIDTH'(1);
    assign good     = (count_in == prev_inc);
    assign run_done = ((int'(run_reg) + 1) == LOCK_CYCLES);
    assign wrap_hit = (prev_reg == ONES) && (count_in == '0);

    // A bad increment only counts as an error when seen while locked; clear
    // and reset override a simultaneous bad sample.
    assign err_inc = valid_in && !clear && (state_reg == LOCKED) && !good;

    sat_counter #(
        .W(ERR_CNT_W)
    ) u_err_counter (
        .clk  (clk),
        .reset(reset),
        .inc  (err_inc),
        .out  (err_count)
    );

    // Main checker state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            prev_reg     <= '0;
            run_reg      <= '0;
            locked_reg   <= 1'b0;
            mismatch_reg <= 1'b0;
            expected_reg <= '0;
            wrap_reg     <= '0;
        end else if (clear) begin
            // Re-acquire from scratch but keep history counters and prev.
            state_reg    <= IDLE;
            run_reg      <= '0;
            locked_reg   <= 1'b0;
            mismatch_reg <= 1'b0;
        end else if (!valid_in) begin
            // Gaps hold everything; they are never errors.
            mismatch_reg <= 1'b0;
        end else begin
            mismatch_reg <= 1'b0;
            prev_reg     <= count_in;
            expected_reg <= count_in + WIDTH'(1);
            case (state_reg)
                IDLE: begin
                    // First sample only seeds prev; nothing to compare yet.
                    state_reg <= ACQUIRE;
                    run_reg   <= '0;
                end
                ACQUIRE: begin
                    if (good) begin
                        if (run_done) begin
                            state_reg  <= LOCKED;
                            locked_reg <= 1'b1;
                            run_reg    <= '0;
                        end else begin
                            run_reg <= run_reg + RUN_W'(1);
                        end
                    end else begin
                        run_reg <= '0;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        if (wrap_hit)
                            wrap_reg <= wrap_reg + WRAP_CNT_W'(1);
                    end else begin
                        mismatch_reg <= 1'b1;
                        locked_reg   <= 1'b0;
                        state_reg    <= ACQUIRE;
                        run_reg      <= '0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    locked_reg <= 1'b0;
                    run_reg    <= '0;
                end
            endcase
        end
    end

    assign locked     = locked_reg;
    assign mismatch   = mismatch_reg;
    assign expected   = expected_reg;
    assign wrap_count = wrap_reg;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Self-checking bench for count_sequence_checker: directed scenarios followed
// by randomized traffic, all compared every cycle against a behavioural model.
module tb_count_sequence_checker;

    localparam int WIDTH       = 4;
    localparam int LOCK_CYCLES = 4;
    localparam int ERR_CNT_W   = 2;
    localparam int WRAP_CNT_W  = 8;
    localparam int MOD         = 1 << WIDTH;
    localparam int ERR_MAX     = (1 << ERR_CNT_W) - 1;
    localparam int WRAP_MOD    = 1 << WRAP_CNT_W;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [WIDTH-1:0]      count_in = '0;
    logic                  valid_in = 1'b0;
    logic                  clear = 1'b0;
    logic                  locked;
    logic                  mismatch;
    logic [WIDTH-1:0]      expected;
    logic [ERR_CNT_W-1:0]  err_count;
    logic [WRAP_CNT_W-1:0] wrap_count;

    int checks = 0;
    int errors = 0;

    // Reference model: a history of accepted samples and a streak of good steps.
    bit m_have_prev;
    int m_prev;
    int m_streak;
    bit m_locked;
    bit m_mismatch;
    int m_expected;
    int m_err;
    int m_wrap;
    int mismatch_pulses;

    always #5 clk = ~clk;

    count_sequence_checker #(
        .WIDTH      (WIDTH),
        .LOCK_CYCLES(LOCK_CYCLES),
        .ERR_CNT_W  (ERR_CNT_W),
        .WRAP_CNT_W (WRAP_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .valid_in  (valid_in),
        .clear     (clear),
        .locked    (locked),
        .mismatch  (mismatch),
        .expected  (expected),
        .err_count (err_count),
        .wrap_count(wrap_count)
    );

    task automatic check(input string tag, input int observed, input int required);
        checks++;
        if (observed != required) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, observed, required, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit clr, input bit v, input int c);
        bit good;
        if (rst) begin
            m_have_prev = 0; m_prev = 0; m_streak = 0; m_locked = 0;
            m_mismatch = 0; m_expected = 0; m_err = 0; m_wrap = 0;
        end else if (clr) begin
            m_have_prev = 0; m_streak = 0; m_locked = 0; m_mismatch = 0;
        end else if (!v) begin
            m_mismatch = 0;
        end else begin
            good = (c == (m_prev + 1) % MOD);
            m_mismatch = 0;
            if (!m_have_prev) begin
                m_have_prev = 1;
                m_streak = 0;
            end else if (m_locked) begin
                if (good) begin
                    if (m_prev == MOD - 1 && c == 0)
                        m_wrap = (m_wrap + 1) % WRAP_MOD;
                end else begin
                    m_mismatch = 1;
                    m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
                    m_locked = 0;
                    m_streak = 0;
                end
            end else if (good) begin
                m_streak++;
                if (m_streak == LOCK_CYCLES) begin
                    m_locked = 1;
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
            m_prev = c;
            m_expected = (c + 1) % MOD;
        end
    endtask

    task automatic compare_all();
        check("locked",     int'(locked),     int'(m_locked));
        check("mismatch",   int'(mismatch),   int'(m_mismatch));
        check("expected",   int'(expected),   m_expected);
        check("err_count",  int'(err_count),  m_err);
        check("wrap_count", int'(wrap_count), m_wrap);
        if (mismatch) mismatch_pulses++;
    endtask

    // One clock cycle: drive on the falling edge, update model at the rising
    // edge, compare just after it.
    task automatic cycle(input bit rst, input bit clr, input bit v, input int c);
        @(negedge clk);
        reset    = rst;
        clear    = clr;
        valid_in = v;
        count_in = WIDTH'(c);
        @(posedge clk);
        model_step(rst, clr, v, c);
        #1;
        $display("cyc rst=%0d clr=%0d v=%0d in=%0d -> locked=%0d mm=%0d exp=%0d err=%0d wrap=%0d",
                 rst, clr, v, c, locked, mismatch, expected, err_count, wrap_count);
        compare_all();
    endtask

    task automatic sample(input int c);
        cycle(1'b0, 1'b0, 1'b1, c);
    endtask

    initial begin
        int r;
        int nxt;
        mismatch_pulses = 0;
        model_step(1'b1, 1'b0, 1'b0, 0);

        // Reset and lock on 0..4.
        cycle(1'b1, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i <= 4; i++) sample(i);
        check("lock_locked", int'(locked), 1);
        check("lock_expected", int'(expected), 5);

        // Valid gap with garbage, then continue at 5, 6.
        sample(5);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 10);
        sample(6);
        check("gap_locked", int'(locked), 1);

        // Mismatch and re-lock.
        sample(7);
        sample(9);
        check("mm_pulse", int'(mismatch), 1);
        check("mm_locked", int'(locked), 0);
        for (int i = 10; i <= 13; i++) sample(i);
        check("relock", int'(locked), 1);

        // Wrap through 15 -> 0.
        sample(14); sample(15); sample(0);
        check("wrap_count", int'(wrap_count), 1);
        sample(1);

        // Clear while locked keeps counters; next sample is a fresh start.
        cycle(1'b0, 1'b1, 1'b0, 0);
        check("clear_locked", int'(locked), 0);
        sample(9);
        sample(12);
        check("clear_first_mm", int'(mismatch), 0);

        // Saturation: lock on 0..4 and inject a bad value, five times.
        mismatch_pulses = 0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i <= 4; i++) sample(i);
            sample(9);
        end
        check("sat_err", int'(err_count), ERR_MAX);
        check("sat_pulses", mismatch_pulses, 5);

        // Upstream counter held in reset while locked: one error, then quiet.
        for (int i = 0; i <= 4; i++) sample(i);
        sample(0); sample(0); sample(0);

        // Reset together with a bad sample while locked.
        for (int i = 0; i <= 5; i++) sample(i);
        cycle(1'b1, 1'b0, 1'b1, 11);
        check("rst_mismatch", int'(mismatch), 0);
        check("rst_err", int'(err_count), 0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            nxt = (m_prev + 1) % MOD;
            if (r < 1)
                cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, MOD - 1)));
            else if (r < 3)
                cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, MOD - 1)));
            else if (r < 15)
                cycle(1'b0, 1'b0, 1'b0, int'($urandom_range(0, MOD - 1)));
            else if (r < 19)
                sample(int'($urandom_range(0, MOD - 1)));
            else if (r < 21)
                sample(m_prev);
            else
                sample(nxt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
